// File: rtl/ventilador_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ventilador_pkg
//  Description : Shared state codes, counter width, default timing values
//                and output decode for the fan motor controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package ventilador_pkg;

    localparam int ESTADO_W = 3;
    localparam int CNT_W    = 8;

    localparam logic [ESTADO_W-1:0] DESLIGADO = 3'd0;
    localparam logic [ESTADO_W-1:0] PARTIDA   = 3'd1;
    localparam logic [ESTADO_W-1:0] BAIXA     = 3'd2;
    localparam logic [ESTADO_W-1:0] ALTA      = 3'd3;
    localparam logic [ESTADO_W-1:0] PARADA    = 3'd4;

    localparam int T_PARTIDA_DEF = 8;
    localparam int T_MIN_DEF     = 4;
    localparam int T_PARADA_DEF  = 6;

    // Motor enable / high-speed select implied by a state code {s1, s2}
    function automatic logic [1:0] decodifica_saidas(input logic [ESTADO_W-1:0] e);
        case (e)
            PARTIDA, BAIXA: decodifica_saidas = 2'b10;
            ALTA:           decodifica_saidas = 2'b11;
            default:        decodifica_saidas = 2'b00;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/ventilador_temporizador.sv
`default_nettype none
// ============================================================================
//  Module      : ventilador_temporizador
//  Description : Dwell counter; clears on request, counts up and saturates
//                at the supplied limit, flags when the limit is reached.
//  Revision    : 1.0 - initial release
// ============================================================================
module ventilador_temporizador
    import ventilador_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             limpa,
    input  logic             incrementa,
    input  logic [CNT_W-1:0] limite,
    output logic [CNT_W-1:0] cnt,
    output logic             atingiu
);

    logic [CNT_W-1:0] r_cnt;

    // Clear has priority; counting stops at the limit so it never wraps
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (limpa) begin
            r_cnt <= '0;
        end else if (incrementa && (r_cnt < limite)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign cnt     = r_cnt;
    assign atingiu = (r_cnt >= limite);

endmodule
`default_nettype wire

// File: rtl/ventilador_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : ventilador_ctrl
//  Description : Fan motor sequencer: soft start, minimum speed dwell,
//                coast-down lockout; registered motor enable / high speed.
//  Revision    : 1.0 - initial release
// ============================================================================
module ventilador_ctrl
    import ventilador_pkg::*;
#(
    parameter int T_PARTIDA = T_PARTIDA_DEF,
    parameter int T_MIN     = T_MIN_DEF,
    parameter int T_PARADA  = T_PARADA_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                a,
    input  logic                b,
    input  logic                c,
    input  logic                d,
    output logic                s1,
    output logic                s2,
    output logic [ESTADO_W-1:0] estado
);

    localparam logic [CNT_W-1:0] c_lim_partida = CNT_W'(T_PARTIDA - 1);
    localparam logic [CNT_W-1:0] c_lim_min     = CNT_W'(T_MIN - 1);
    localparam logic [CNT_W-1:0] c_lim_parada  = CNT_W'(T_PARADA - 1);

    logic [ESTADO_W-1:0] r_estado;
    logic [ESTADO_W-1:0] w_prox;
    logic                r_s1;
    logic                r_s2;
    logic                w_quer_alta;
    logic                w_limpa;
    logic                w_incrementa;
    logic                w_atingiu;
    logic [CNT_W-1:0]    w_limite;
    logic [CNT_W-1:0]    w_cnt;

    assign w_quer_alta = b | (c & d);

    // Next state, active timer limit and count enable for the current state
    always_comb begin
        w_prox       = r_estado;
        w_limite     = '0;
        w_incrementa = 1'b0;
        case (r_estado)
            DESLIGADO: begin
                if (a) w_prox = PARTIDA;
            end
            PARTIDA: begin
                w_limite     = c_lim_partida;
                w_incrementa = 1'b1;
                if (!a)                          w_prox = PARADA;
                else if (w_cnt == c_lim_partida) w_prox = BAIXA;
            end
            BAIXA: begin
                w_limite     = c_lim_min;
                w_incrementa = 1'b1;
                if (!a)                            w_prox = PARADA;
                else if (w_quer_alta && w_atingiu) w_prox = ALTA;
            end
            ALTA: begin
                w_limite     = c_lim_min;
                w_incrementa = 1'b1;
                if (!a)                             w_prox = PARADA;
                else if (!w_quer_alta && w_atingiu) w_prox = BAIXA;
            end
            PARADA: begin
                // Power request is deliberately ignored during coast-down
                w_limite     = c_lim_parada;
                w_incrementa = 1'b1;
                if (w_cnt == c_lim_parada) w_prox = DESLIGADO;
            end
            default: begin
                w_prox = DESLIGADO;
            end
        endcase
    end

    // Every state change restarts the dwell count from zero
    assign w_limpa = (w_prox != r_estado);

    ventilador_temporizador u_temporizador (
        .clk        (clk),
        .rst        (reset),
        .limpa      (w_limpa),
        .incrementa (w_incrementa),
        .limite     (w_limite),
        .cnt        (w_cnt),
        .atingiu    (w_atingiu)
    );

    // State and outputs registered together so s1/s2 always match estado
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_estado <= DESLIGADO;
            r_s1     <= 1'b0;
            r_s2     <= 1'b0;
        end else begin
            r_estado       <= w_prox;
            {r_s1, r_s2}   <= decodifica_saidas(w_prox);
        end
    end

    assign s1     = r_s1;
    assign s2     = r_s2;
    assign estado = r_estado;

endmodule
`default_nettype wire

// File: tb/tb_ventilador_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ventilador_ctrl
//  Description : Self-checking bench for ventilador_ctrl (default timing and
//                an all-ones timing instance).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ventilador_ctrl;

    logic       clk;
    logic       reset;
    logic       a, b, c, d;
    logic       s1, s2;
    logic [2:0] estado;
    logic       s1_t1, s2_t1;
    logic [2:0] estado_t1;

    int checks = 0;
    int errors = 0;
    logic [4:0] sb[$];

    ventilador_ctrl dut (
        .clk(clk), .reset(reset), .a(a), .b(b), .c(c), .d(d),
        .s1(s1), .s2(s2), .estado(estado)
    );

    ventilador_ctrl #(.T_PARTIDA(1), .T_MIN(1), .T_PARADA(1)) dut_t1 (
        .clk(clk), .reset(reset), .a(a), .b(b), .c(c), .d(d),
        .s1(s1_t1), .s2(s2_t1), .estado(estado_t1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Expected {s1, s2, estado} for a state code
    function automatic logic [4:0] exp_out(input int e);
        logic [2:0] st;
        st = 3'(e);
        case (st)
            3'd1, 3'd2: exp_out = {2'b10, st};
            3'd3:       exp_out = {2'b11, st};
            default:    exp_out = {2'b00, st};
        endcase
    endfunction

    task automatic do_reset();
        reset = 1'b1; a = 0; b = 0; c = 0; d = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        logic [4:0] got, exp;
        @(negedge clk);
        reset = 1'b1;
        sb.push_back(exp_out(0));
        #1;
        got = {s1, s2, estado}; exp = sb.pop_front(); checks++;
        if (got !== exp) begin
            errors++; $display("FAIL reset_state got=%b exp=%b", got, exp);
        end
        do_reset();
    endtask

    task automatic test_soft_start();
        logic [4:0] got, exp;
        do_reset();
        for (int k = 0; k < 11; k++) begin
            @(negedge clk); a = 1; b = 0;
            sb.push_back(exp_out(k < 8 ? 1 : 2));
            @(posedge clk); #1;
            got = {s1, s2, estado}; exp = sb.pop_front(); checks++;
            if (got !== exp) begin
                errors++; $display("FAIL soft_start edge=%0d got=%b exp=%b", k, got, exp);
            end
        end
    endtask

    // mode 0: b, mode 1: c&d, mode 2: only c (no turbo request)
    task automatic test_turbo(input int mode);
        logic [4:0] got, exp;
        int e;
        do_reset();
        for (int k = 0; k < 14; k++) begin
            @(negedge clk); a = 1;
            b = (mode == 0); c = (mode != 0); d = (mode == 1);
            e = (k < 8) ? 1 : ((k < 12 || mode == 2) ? 2 : 3);
            sb.push_back(exp_out(e));
            @(posedge clk); #1;
            got = {s1, s2, estado}; exp = sb.pop_front(); checks++;
            if (got !== exp) begin
                errors++; $display("FAIL turbo mode=%0d edge=%0d got=%b exp=%b", mode, k, got, exp);
            end
        end
    endtask

    task automatic test_anti_chatter();
        logic [4:0] got, exp;
        int e;
        do_reset();
        for (int k = 0; k < 19; k++) begin
            @(negedge clk); a = 1;
            b = (k <= 12) || (k == 15) || (k == 16);
            e = (k < 8) ? 1 : (k < 12) ? 2 : (k < 17) ? 3 : 2;
            sb.push_back(exp_out(e));
            @(posedge clk); #1;
            got = {s1, s2, estado}; exp = sb.pop_front(); checks++;
            if (got !== exp) begin
                errors++; $display("FAIL anti_chatter edge=%0d got=%b exp=%b", k, got, exp);
            end
        end
    endtask

    task automatic test_stop_lockout();
        logic [4:0] got, exp;
        int e;
        do_reset();
        for (int k = 0; k < 24; k++) begin
            @(negedge clk);
            a = !(k == 15 || k == 16); b = 1;
            e = (k < 8) ? 1 : (k < 12) ? 2 : (k < 15) ? 3 : (k <= 20) ? 4 : (k == 21) ? 0 : 1;
            sb.push_back(exp_out(e));
            @(posedge clk); #1;
            got = {s1, s2, estado}; exp = sb.pop_front(); checks++;
            if (got !== exp) begin
                errors++; $display("FAIL stop_lockout edge=%0d got=%b exp=%b", k, got, exp);
            end
        end
    endtask

    task automatic test_abort();
        logic [4:0] got, exp;
        int e;
        do_reset();
        for (int k = 0; k < 13; k++) begin
            @(negedge clk); a = (k < 4); b = 1;
            e = (k < 4) ? 1 : (k <= 9) ? 4 : 0;
            sb.push_back(exp_out(e));
            @(posedge clk); #1;
            got = {s1, s2, estado}; exp = sb.pop_front(); checks++;
            if (got !== exp) begin
                errors++; $display("FAIL abort edge=%0d got=%b exp=%b", k, got, exp);
            end
        end
    endtask

    task automatic test_async_reset();
        logic [4:0] got, exp;
        do_reset();
        for (int k = 0; k < 14; k++) begin
            @(negedge clk); a = 1; b = 1;
        end
        @(posedge clk); #1;
        sb.push_back(exp_out(3));
        got = {s1, s2, estado}; exp = sb.pop_front(); checks++;
        if (got !== exp) begin
            errors++; $display("FAIL async_reset_pre got=%b exp=%b", got, exp);
        end
        #2; reset = 1'b1;
        sb.push_back(exp_out(0));
        #1;
        got = {s1, s2, estado}; exp = sb.pop_front(); checks++;
        if (got !== exp) begin
            errors++; $display("FAIL async_reset_immediate got=%b exp=%b", got, exp);
        end
        @(negedge clk); reset = 1'b0; a = 1; b = 1;
        sb.push_back(exp_out(1));
        @(posedge clk); #1;
        got = {s1, s2, estado}; exp = sb.pop_front(); checks++;
        if (got !== exp) begin
            errors++; $display("FAIL async_reset_restart got=%b exp=%b", got, exp);
        end
    endtask

    task automatic test_t_one();
        logic [4:0] got, exp;
        int av[7] = '{1, 1, 1, 1, 0, 1, 1};
        int bv[7] = '{0, 1, 1, 0, 0, 0, 0};
        int ev[7] = '{1, 2, 3, 2, 4, 0, 1};
        do_reset();
        for (int k = 0; k < 7; k++) begin
            @(negedge clk); a = av[k][0]; b = bv[k][0]; c = 0; d = 0;
            sb.push_back(exp_out(ev[k]));
            @(posedge clk); #1;
            got = {s1_t1, s2_t1, estado_t1}; exp = sb.pop_front(); checks++;
            if (got !== exp) begin
                errors++; $display("FAIL t_one edge=%0d got=%b exp=%b", k, got, exp);
            end
        end
    endtask

    initial begin
        reset = 1'b1; a = 0; b = 0; c = 0; d = 0;
        test_reset();
        test_soft_start();
        test_turbo(0);
        test_turbo(1);
        test_turbo(2);
        test_anti_chatter();
        test_stop_lockout();
        test_abort();
        test_async_reset();
        test_t_one();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ventilador_ctrl.md
# ventilador_ctrl

Sequential controller for the fan motor stage: converts the power request `a`, manual turbo `b` and temperature sensors `c`/`d` into sequenced motor-enable (`s1`) and high-speed (`s2`) commands. Enforces a low-speed soft start, a minimum dwell before each speed change, and a coast-down lockout before restart. Sits between the panel/sensor inputs and the motor relay driver.

## Interface
- `T_PARTIDA`, 8: soft-start duration in cycles; range 1..255.
- `T_MIN`, 4: minimum cycles in BAIXA/ALTA before a speed change; range 1..255.
- `T_PARADA`, 6: coast-down lockout in cycles; range 1..255.

Ports:
- `clk` input 1: single system clock, rising edge.
- `reset` input 1: asynchronous, active-high; all state cleared immediately.
- `a` input 1: power request, level (1 = run).
- `b` input 1: manual turbo request, level.
- `c` input 1: temperature sensor 1 hot.
- `d` input 1: temperature sensor 2 hot.
- `s1` output 1: motor enable, registered.
- `s2` output 1: high-speed select, registered.
- `estado` output 3: current state code, registered.

## Operation
- Inputs are synchronous to `clk` and sampled directly, with no synchronizer.
- `quer_alta = b | (c & d)`.
- States and codes: DESLIGADO=0, PARTIDA=1, BAIXA=2, ALTA=3, PARADA=4.
- Outputs `(s1,s2)` are decoded from the state register:
  - DESLIGADO: 0,0
  - PARTIDA: 1,0
  - BAIXA: 1,0
  - ALTA: 1,1
  - PARADA: 0,0
- One 8-bit counter `cnt` is cleared to 0 on every state change.
- Transitions, evaluated at each rising edge:
  - DESLIGADO: `a`=1 → PARTIDA.
  - PARTIDA: `a`=0 → PARADA (priority). Otherwise `cnt==T_PARTIDA-1` → BAIXA, else `cnt++`.
  - BAIXA: `a`=0 → PARADA (priority). Otherwise `quer_alta` and `cnt>=T_MIN-1` → ALTA. Otherwise `cnt` increments, saturating at `T_MIN-1`.
  - ALTA: `a`=0 → PARADA (priority). Otherwise `!quer_alta` and `cnt>=T_MIN-1` → BAIXA. Otherwise `cnt` saturates as in BAIXA.
  - PARADA: `a` is ignored. `cnt==T_PARADA-1` → DESLIGADO, else `cnt++`.
- Unused state codes 5..7 → DESLIGADO on the next edge, with outputs 0,0.

## Timing
- Reset: state DESLIGADO, `cnt`=0, `s1`=0, `s2`=0, `estado`=0, all asynchronously. Reset released mid-operation resumes from DESLIGADO.
- Latency is one edge: an input change before edge k is reflected on the outputs after edge k.
- Durations:
  - PARTIDA lasts exactly `T_PARTIDA` cycles.
  - BAIXA/ALTA dwell is at least `T_MIN` cycles.
  - PARADA lasts exactly `T_PARADA` cycles.
  - The earliest restart is one cycle after leaving PARADA.
- Turbo is never granted directly from PARTIDA; `quer_alta` during PARTIDA has no effect until BAIXA's dwell has elapsed.
- `quer_alta` toggling faster than `T_MIN` causes no speed change until the dwell expires. The level present at that edge decides.
- Simultaneous `a`=0 and a pending speed change: the PARADA transition wins.
- `T_*`=1: the state is held for one cycle, and the counter compare is at 0.

## Structure
- Shared package `ventilador_pkg` holds:
  - state encodings, `ESTADO_W`=3;
  - default `T_*` values;
  - counter width `CNT_W`=8.
- Sub-module `ventilador_temporizador` provides the counter, with inputs `limpa`, `incrementa` and `limite` and outputs `cnt` and `atingiu` (`cnt>=limite`). It saturates at `limite`.
- FSM next-state logic lives in the top-level `ventilador_ctrl`.

## Test plan
- Soft start, defaults: reset, then raise `a` before edge 0.
  - Required: `s1`=1/`s2`=0 from edge 0, `estado`=2 at edge 8, `s2` stays 0 throughout.
- Turbo after dwell: as above with `b`=1 held.
  - Required: `estado`=3 and `s2`=1 exactly at edge 12; with `c`=`d`=1 and `b`=0 the result is identical.
- Anti-chatter: in ALTA, drop `b` for 2 cycles, then restore.
  - Required: no change while `cnt` has not reached 3. A drop held at a dwell-expired edge gives `s2`=0 the following edge.
- Stop and lockout: drop `a` in ALTA at edge m, then re-raise `a` at m+2.
  - Required: `s1`=`s2`=0 from m, `estado`=4 until m+6, `estado`=0 at m+6, `estado`=1 at m+7.
- Abort during soft start: drop `a` at PARTIDA `cnt`=3.
  - Required: PARADA the next edge, never reaching BAIXA.
- Async reset: assert `reset` between edges while in ALTA.
  - Required: `s1`/`s2`/`estado` go to 0 before the next edge. After release with `a`=1, PARTIDA at the first edge.
